iddmm_result_sel: RTL and testbench

- Sits directly downstream of the IDDMM calculation core.
- Captures its two final-iteration word streams: raw result A, and A−P, both least-significant word first.
- Latches the final-subtraction decision from cal_done/cal_sign, then streams the selected N-word residue out over a valid/ready interface to the Paillier-level consumer.
- Isolates the free-running core pipeline from a back-pressured consumer.

---
 rtl/iddmm_result_sel_pkg.sv | 13 +
 rtl/iddmm_result_sel_word_buf.sv | 45 ++++
 rtl/iddmm_result_sel.sv | 120 ++++++++++++
 tb/tb_iddmm_result_sel.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iddmm_result_sel_pkg.sv
// Shared constants and types for the IDDMM final-result selection stage.
package iddmm_pkg;
   localparam int IDDMM_K = 256;
   localparam int IDDMM_N = 16;

   localparam logic SEL_RAW = 1'b0;
   localparam logic SEL_SUB = 1'b1;

   typedef enum logic {
      S_COLLECT = 1'b0,
      S_OUT     = 1'b1
   } state_t;
endpackage

// File: rtl/iddmm_result_sel_word_buf.sv
// N-word result buffer: in-order writes, drop pulse on a refused strobe, async-index read.
// Write latency 1 cycle; no backpressure, refused words are dropped and flagged via o_drop.
module iddmm_word_buf
   import iddmm_pkg::*;
#(
   parameter int K      = IDDMM_K,
   parameter int N      = IDDMM_N,
   parameter int ADDR_W = $clog2(N),
   parameter int CNT_W  = $clog2(N + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [K-1:0]      i_wr_data,
   input  logic              i_wr_allow,
   input  logic              i_clr,
   input  logic [ADDR_W-1:0] i_rd_idx,
   output logic [K-1:0]      o_rd_data,
   output logic [CNT_W-1:0]  o_cnt,
   output logic              o_full,
   output logic              o_drop
);
   logic [K-1:0]     r_mem [N];
   logic [CNT_W-1:0] r_cnt;
   logic             w_wr_ok;

   assign o_full    = (r_cnt == CNT_W'(N));
   assign w_wr_ok   = i_wr_en && i_wr_allow && !o_full;
   assign o_drop    = i_wr_en && !w_wr_ok;
   assign o_cnt     = r_cnt;
   assign o_rd_data = r_mem[i_rd_idx];

   // Clearing only the counter is enough: stale words are never read before being rewritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         for (int i = 0; i < N; i++) r_mem[i] <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (w_wr_ok) begin
         r_mem[r_cnt[ADDR_W-1:0]] <= i_wr_data;
         r_cnt                    <= r_cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/iddmm_result_sel.sv
// Buffers raw/subtracted IDDMM words, streams the chosen N-word residue; first word 1 cycle after last needed input, held while res_ready=0.
// IDDMM_SEL_CONST_TIME_EN: start waits for both buffers so timing does not reveal cal_sign.
module iddmm_result_sel
   import iddmm_pkg::*;
#(
   parameter int K      = IDDMM_K,
   parameter int N      = IDDMM_N,
   parameter int ADDR_W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         fifo_wr_en_a,
   input  logic [K-1:0] fifo_wr_data_a,
   input  logic         fifo_wr_en_sub,
   input  logic [K-1:0] fifo_wr_data_sub,
   input  logic         cal_done,
   input  logic         cal_sign,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [K-1:0] res_data,
   output logic         res_last,
   output logic         res_sel,
   output logic         busy,
   output logic         err_ovf
);
   localparam int                CNT_W    = $clog2(N + 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

   state_t            r_state;
   logic              r_sel_vld, r_sel, r_valid, r_last, r_err;
   logic [K-1:0]      r_data;
   logic [ADDR_W-1:0] r_rd_idx;

   logic              w_collect, w_hs, w_final, w_go, w_dec_ok, w_dec_err;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [K-1:0]      w_a_data, w_sub_data, w_sel_data;
   logic [CNT_W-1:0]  w_cnt_a, w_cnt_sub;
   logic              w_full_a, w_full_sub, w_sel_full, w_drop_a, w_drop_sub;

   assign w_collect = (r_state == S_COLLECT);
   assign w_hs      = r_valid && res_ready;
   assign w_final   = !w_collect && w_hs && (r_rd_idx == LAST_IDX);
   // Entry loads word 0; each handshake prefetches the next word.
   assign w_rd_addr = w_collect ? '0 : r_rd_idx + ADDR_W'(1);

   iddmm_word_buf #(.K(K), .N(N), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_buf_a (
      .clk(clk), .rst(rst), .i_wr_en(fifo_wr_en_a), .i_wr_data(fifo_wr_data_a),
      .i_wr_allow(w_collect), .i_clr(w_final), .i_rd_idx(w_rd_addr),
      .o_rd_data(w_a_data), .o_cnt(w_cnt_a), .o_full(w_full_a), .o_drop(w_drop_a)
   );

   iddmm_word_buf #(.K(K), .N(N), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_buf_sub (
      .clk(clk), .rst(rst), .i_wr_en(fifo_wr_en_sub), .i_wr_data(fifo_wr_data_sub),
      .i_wr_allow(w_collect), .i_clr(w_final), .i_rd_idx(w_rd_addr),
      .o_rd_data(w_sub_data), .o_cnt(w_cnt_sub), .o_full(w_full_sub), .o_drop(w_drop_sub)
   );

   assign w_sel_data = (r_sel == SEL_SUB) ? w_sub_data : w_a_data;
   assign w_sel_full = (r_sel == SEL_SUB) ? w_full_sub : w_full_a;

`ifdef IDDMM_SEL_CONST_TIME_EN
   assign w_go = r_sel_vld && w_sel_full && w_full_a && w_full_sub;
`else
   assign w_go = r_sel_vld && w_sel_full;
`endif

   assign w_dec_ok  = cal_done && w_collect && !r_sel_vld;
   assign w_dec_err = cal_done && !w_dec_ok;

   assign res_valid = r_valid;
   assign res_data  = r_data;
   assign res_last  = r_last;
   assign res_sel   = r_sel;
   assign err_ovf   = r_err;
   assign busy      = !w_collect || (w_cnt_a != '0) || (w_cnt_sub != '0) || r_sel_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_COLLECT;
         r_sel_vld <= 1'b0;
         r_sel     <= SEL_RAW;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_err     <= 1'b0;
         r_data    <= '0;
         r_rd_idx  <= '0;
      end else begin
         r_err <= r_err || w_drop_a || w_drop_sub || w_dec_err;
         if (w_dec_ok) begin
            r_sel_vld <= 1'b1;
            r_sel     <= cal_sign;
         end
         case (r_state)
            S_COLLECT: begin
               if (w_go) begin
                  r_state  <= S_OUT;
                  r_valid  <= 1'b1;
                  r_data   <= w_sel_data;
                  r_rd_idx <= '0;
                  r_last   <= (N == 1);
               end
            end
            S_OUT: begin
               if (w_final) begin
                  r_state   <= S_COLLECT;
                  r_valid   <= 1'b0;
                  r_last    <= 1'b0;
                  r_sel_vld <= 1'b0;
                  r_rd_idx  <= '0;
               end else if (w_hs) begin
                  r_data   <= w_sel_data;
                  r_rd_idx <= r_rd_idx + ADDR_W'(1);
                  r_last   <= ((r_rd_idx + ADDR_W'(1)) == LAST_IDX);
               end
            end
            default: r_state <= S_COLLECT;
         endcase
      end
   end
endmodule

// File: tb/tb_iddmm_result_sel.sv
// Self-checking bench for iddmm_result_sel (N=4): directed scenarios plus randomized operations
// checked against expected word order, start cycle, hold behaviour and error flag.
module tb_iddmm_result_sel;
   localparam int K     = 256;
   localparam int N     = 4;
   localparam int LIMIT = 200;

   logic         clk = 1'b0;
   logic         rst;
   logic         fifo_wr_en_a, fifo_wr_en_sub, cal_done, cal_sign, res_ready;
   logic [K-1:0] fifo_wr_data_a, fifo_wr_data_sub;
   logic         res_valid, res_last, res_sel, busy, err_ovf;
   logic [K-1:0] res_data;

   iddmm_result_sel #(.K(K), .N(N), .ADDR_W(2)) dut (
      .clk(clk), .rst(rst),
      .fifo_wr_en_a(fifo_wr_en_a), .fifo_wr_data_a(fifo_wr_data_a),
      .fifo_wr_en_sub(fifo_wr_en_sub), .fifo_wr_data_sub(fifo_wr_data_sub),
      .cal_done(cal_done), .cal_sign(cal_sign),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_last(res_last), .res_sel(res_sel), .busy(busy), .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   int           n_chk = 0;
   int           n_fail = 0;
   int           a_t[$], s_t[$], d_t[$];
   logic [K-1:0] a_d[$], s_d[$];
   logic         d_s[$];
   int           rdy_mode, rdy_from;
   logic         exp_err;

   task automatic check(input string tag, input logic [K-1:0] obs, input logic [K-1:0] want);
      n_chk++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [K-1:0] rnd_word();
      logic [K-1:0] w;
      for (int i = 0; i < K / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic clear_op();
      a_t.delete(); s_t.delete(); d_t.delete();
      a_d.delete(); s_d.delete(); d_s.delete();
      rdy_mode = 0;
      rdy_from = 0;
   endtask

   task automatic push_a(input int t, input logic [K-1:0] d);
      a_t.push_back(t); a_d.push_back(d);
   endtask

   task automatic push_s(input int t, input logic [K-1:0] d);
      s_t.push_back(t); s_d.push_back(d);
   endtask

   task automatic push_d(input int t, input logic s);
      d_t.push_back(t); d_s.push_back(s);
   endtask

   task automatic set_idle();
      fifo_wr_en_a = 1'b0; fifo_wr_en_sub = 1'b0;
      cal_done = 1'b0; cal_sign = 1'b0; res_ready = 1'b0;
   endtask

   // Times are iteration indices relative to op start; an input driven at t is registered at edge t+1.
   task automatic run_op(input string name, input int rst_after);
      logic [K-1:0] exp_q[$];
      logic         sign, pv, pr, pl, r;
      logic [K-1:0] pd;
      int           start, target, c, hs, first_c, ia, is, id, n_pre_a, n_pre_s, k;
      sign = d_s[0];
      for (int i = 0; i < N; i++) exp_q.push_back(sign ? s_d[i] : a_d[i]);
      start = imax(sign ? s_t[N-1] : a_t[N-1], d_t[0]) + 2;
`ifdef IDDMM_SEL_CONST_TIME_EN
      start = imax(start, imax(a_t[N-1], s_t[N-1]) + 2);
`endif
      n_pre_a = 0; n_pre_s = 0;
      foreach (a_t[i]) if (a_t[i] < start) n_pre_a++; else exp_err = 1'b1;
      foreach (s_t[i]) if (s_t[i] < start) n_pre_s++; else exp_err = 1'b1;
      if (n_pre_a > N || n_pre_s > N || d_t.size() > 1) exp_err = 1'b1;

      target = (rst_after >= 0) ? rst_after : N;
      hs = 0; first_c = -1; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
      ia = 0; is = 0; id = 0; c = 0;
      while (hs < target && c < LIMIT) begin
         if (c == start - 1) begin
            check({name, " busy_pre"}, K'(busy), K'(1));
            check({name, " valid_early"}, K'(res_valid), K'(0));
         end
         if (res_valid === 1'b1 && first_c < 0) begin
            first_c = c;
            check({name, " start_cycle"}, K'(c), K'(start));
            check({name, " res_sel"}, K'(res_sel), K'(sign));
         end
         if (pv && !pr) begin
            check({name, " hold_ctl"}, K'({res_valid, res_last}), K'({1'b1, pl}));
            check({name, " hold_dat"}, res_data, pd);
         end
         k = (first_c >= 0) ? (c - first_c) % 4 : 1;
         case (rdy_mode)
            0:       r = 1'b1;
            1:       r = (k == 0) || (k == 3);
            2:       r = 1'($urandom_range(0, 1));
            default: r = (c >= rdy_from);
         endcase
         res_ready = r;
         if (res_valid === 1'b1 && r) begin
            check({name, " data"}, res_data, exp_q[hs]);
            check({name, " last"}, K'(res_last), K'(hs == N - 1));
            hs++;
         end
         pv = res_valid; pd = res_data; pl = res_last; pr = r;

         fifo_wr_en_a = 1'b0;
         if (ia < a_t.size() && a_t[ia] == c) begin
            fifo_wr_en_a = 1'b1; fifo_wr_data_a = a_d[ia]; ia++;
         end
         fifo_wr_en_sub = 1'b0;
         if (is < s_t.size() && s_t[is] == c) begin
            fifo_wr_en_sub = 1'b1; fifo_wr_data_sub = s_d[is]; is++;
         end
         cal_done = 1'b0;
         if (id < d_t.size() && d_t[id] == c) begin
            cal_done = 1'b1; cal_sign = d_s[id]; id++;
         end
         @(posedge clk); #1;
         c++;
      end
      set_idle();
      check({name, " handshakes"}, K'(hs), K'(target));

      if (rst_after >= 0) begin
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         exp_err = 1'b0;
         check({name, " rst_valid"}, K'(res_valid), K'(0));
         check({name, " rst_last"}, K'(res_last), K'(0));
         check({name, " rst_busy"}, K'(busy), K'(0));
         check({name, " rst_err"}, K'(err_ovf), K'(0));
      end else begin
         check({name, " end_valid"}, K'({res_valid, res_last}), K'(0));
         check({name, " end_busy"}, K'(busy), K'(0));
         check({name, " end_err"}, K'(err_ovf), K'(exp_err));
         check({name, " end_sel"}, K'(res_sel), K'(sign));
      end
   endtask

   initial begin
      int           t1[N], t2[N];
      int           t, mx;
      logic         sg;
      logic [K-1:0] w;

      rst = 1'b1;
      fifo_wr_data_a = '0; fifo_wr_data_sub = '0;
      set_idle();
      exp_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset valid", K'(res_valid), K'(0));
      check("reset data", res_data, '0);
      check("reset last", K'(res_last), K'(0));
      check("reset sel", K'(res_sel), K'(0));
      check("reset busy", K'(busy), K'(0));
      check("reset err", K'(err_ovf), K'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic subtract select, decision on the last SUB strobe.
      clear_op();
      for (int i = 0; i < N; i++) begin
         w = K'(32'hA0 + i); push_a(i, w);
         w = K'(32'h50 + i); push_s(N + i, w);
      end
      push_d(2 * N - 1, 1'b1);
      run_op("basic_sub", -1);

      // Raw select under 1,0,0,1 backpressure.
      d_t.delete(); d_s.delete();
      push_d(2 * N - 1, 1'b0);
      rdy_mode = 1;
      run_op("raw_bp", -1);

      // Decision ten cycles before any word.
      clear_op();
      push_d(0, 1'b0);
      for (int i = 0; i < N; i++) begin
         push_a(10 + i, rnd_word());
         push_s(10 + i, rnd_word());
      end
      rdy_mode = 2;
      run_op("early_dec", -1);

      // A words finish six cycles after SUB; ready held off until all traffic is over.
      clear_op();
      for (int i = 0; i < N; i++) begin
         push_s(i, rnd_word());
         push_a(N + 2 + i, rnd_word());
      end
      push_d(N - 1, 1'b1);
      rdy_mode = 3;
      rdy_from = 12;
      run_op("const_time", -1);

      // Fifth A strobe and a duplicate decision of opposite sign.
      clear_op();
      for (int i = 0; i <= N; i++) push_a(i, rnd_word());
      for (int i = 0; i < N; i++) push_s(i, rnd_word());
      push_d(5, 1'b0);
      push_d(6, 1'b1);
      run_op("overflow", -1);

      // Reset after two handshakes.
      clear_op();
      for (int i = 0; i < N; i++) begin
         push_a(i, rnd_word());
         push_s(i + 1, rnd_word());
      end
      push_d(N + 1, 1'($urandom_range(0, 1)));
      run_op("rst_mid", 2);

      // Randomized operations; the selected stream never finishes before the other one.
      for (int n = 0; n < 8; n++) begin
         clear_op();
         t = $urandom_range(0, 2);
         for (int i = 0; i < N; i++) begin t1[i] = t; t += $urandom_range(1, 3); end
         t = $urandom_range(0, 2);
         for (int i = 0; i < N; i++) begin t2[i] = t; t += $urandom_range(1, 3); end
         sg = 1'($urandom_range(0, 1));
         if (t1[N-1] < t2[N-1]) begin
            for (int i = 0; i < N; i++) begin t = t1[i]; t1[i] = t2[i]; t2[i] = t; end
         end
         for (int i = 0; i < N; i++) begin
            if (sg) begin push_s(t1[i], rnd_word()); push_a(t2[i], rnd_word()); end
            else    begin push_a(t1[i], rnd_word()); push_s(t2[i], rnd_word()); end
         end
         mx = t1[N-1];
         push_d($urandom_range(0, mx + 2), sg);
         rdy_mode = $urandom_range(0, 2);
         run_op($sformatf("rand%0d", n), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
